// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between execute-stage control and the iterative mul/div unit.
// Latency: none, wiring only.
// Backpressure: requester may only assert start while ready is high; done is a pulse with no stall.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  flush;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  tag_out;

  modport master (
    output start, op, data1, data2, tag_in, flush,
    input  ready, busy, done, result, tag_out
  );

  modport slave (
    input  start, op, data1, data2, tag_in, flush,
    output ready, busy, done, result, tag_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Bit-serial RV32M multiply/divide: shift-add multiply, restoring divide on operand magnitudes.
// Latency: done pulses DATA_WIDTH+1 cycles after accept; divide-by-zero/overflow in 1 cycle.
// Backpressure: ready low while busy, start ignored; flush kills in-flight work without done.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [2:0]           op_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic                 sgn_q;    // sign of product or quotient
  logic                 sgn_r;    // sign of remainder (dividend sign)
  logic [W-1:0]         b_r;      // multiplicand or divisor magnitude
  logic [2*W-1:0]       acc;      // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [CW-1:0]        cnt;
  logic [W-1:0]         result_r;
  logic [TAG_WIDTH-1:0] tag_out_r;

  logic                 is_div, a_sgn, b_sgn, a_neg, b_neg, special;
  logic [W-1:0]         a_mag, b_mag, special_res;
  logic [W:0]           mul_sum, rem_sh, trial;
  logic [2*W:0]         mul_tmp;
  logic [2*W-1:0]       acc_nxt, prod;
  logic [W-1:0]         quot, rem, fin_res;

  // Accept-time decode: operand signedness, magnitudes and the cases that skip iteration
  always_comb begin
    is_div      = bus.op[2];
    a_sgn       = is_div ? ~bus.op[0] : (bus.op != 3'd3);
    b_sgn       = is_div ? ~bus.op[0] : (bus.op[2:1] == 2'b00);
    a_neg       = a_sgn & bus.data1[W-1];
    b_neg       = b_sgn & bus.data2[W-1];
    a_mag       = a_neg ? -bus.data1 : bus.data1;
    b_mag       = b_neg ? -bus.data2 : bus.data2;
    special     = 1'b0;
    special_res = '0;
    if (is_div && (bus.data2 == '0)) begin
      special     = 1'b1;
      special_res = bus.op[1] ? bus.data1 : '1;
    end else if (is_div && !bus.op[0] && (bus.data1 == {1'b1, {(W-1){1'b0}}}) && (bus.data2 == '1)) begin
      special     = 1'b1;
      special_res = bus.op[1] ? '0 : bus.data1;
    end
  end

  // One iteration of the unsigned core, plus sign fix-up of the final value
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_r} : '0);
    mul_tmp = {mul_sum, acc[W-1:0]};
    rem_sh  = {acc[2*W-1:W], acc[W-1]};
    trial   = rem_sh - {1'b0, b_r};
    acc_nxt = mul_tmp[2*W:1];
    if (op_r[2]) begin
      if (!trial[W]) acc_nxt = {trial[W-1:0], acc[W-2:0], 1'b1};
      else           acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
    prod = sgn_q ? -acc_nxt : acc_nxt;
    quot = acc_nxt[W-1:0];
    rem  = acc_nxt[2*W-1:W];
    if (op_r[2])              fin_res = op_r[1] ? (sgn_r ? -rem : rem) : (sgn_q ? -quot : quot);
    else if (op_r == 3'd0)    fin_res = prod[W-1:0];
    else                      fin_res = prod[2*W-1:W];
  end

  // Control FSM with operand latching, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= '0;
      tag_r     <= '0;
      sgn_q     <= 1'b0;
      sgn_r     <= 1'b0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      result_r  <= '0;
      tag_out_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_r  <= bus.op;
            tag_r <= bus.tag_in;
            sgn_q <= a_neg ^ b_neg;
            sgn_r <= a_neg;
            cnt   <= '0;
            if (is_div) begin
              b_r <= b_mag;
              acc <= {{W{1'b0}}, a_mag};
            end else begin
              b_r <= a_mag;
              acc <= {{W{1'b0}}, b_mag};
            end
            if (special) begin
              result_r  <= special_res;
              tag_out_r <= bus.tag_in;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W-1)) begin
              result_r  <= fin_res;
              tag_out_r <= tag_r;
              state     <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and result outputs; a flush in DONE suppresses that cycle's pulse
  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE) && !bus.flush;
  assign bus.result  = result_r;
  assign bus.tag_out = tag_out_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: all eight ops, special cases, flush, stray start and mid-op reset.
// Latency: cycle n is the period after the n-th clock edge counting the accept edge as edge 1.
// Backpressure: start is only raised when ready is observed high.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic seen;

  muldiv_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

  muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Present one request at a negedge; returns in cycle 1 with inputs scrambled
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    check("ready_before_accept", {31'b0, bus.ready}, 32'd1);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.data1  = a;
    bus.data2  = b;
    bus.tag_in = t;
    @(negedge clk);
    cyc        = 1;
    bus.start  = 1'b0;
    bus.op     = ~o;
    bus.data1  = ~a;
    bus.data2  = 32'h5;
    bus.tag_in = ~t;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input logic [31:0] exp_res, input logic [4:0] exp_tag);
    while (!bus.done && cyc < 100) step();
    check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_result"}, bus.result, exp_res);
    check({name, "_tag"}, {27'b0, bus.tag_out}, {27'b0, exp_tag});
    step();
    check({name, "_ready_after"}, {31'b0, bus.ready}, 32'd1);
    check({name, "_done_one_cycle"}, {31'b0, bus.done}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input int exp_cyc, input logic [31:0] exp_res);
    issue(o, a, b, t);
    wait_done(name, exp_cyc, exp_res, t);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.data1  = '0;
    bus.data2  = '0;
    bus.tag_in = '0;
    bus.flush  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_tag", {27'b0, bus.tag_out}, 32'd0);

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  33, 32'hFFFFFFEB);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1,  33, 32'h40000000);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  33, 32'hFFFFFFFF);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  33, 32'hFFFFFFFE);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  33, 32'hFFFFFFFD);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  33, 32'hFFFFFFFF);
    run_op("divu",   3'd5, 32'd100,      32'd7,        5'd7,  33, 32'd14);
    run_op("remu",   3'd7, 32'd100,      32'd7,        5'd8,  33, 32'd2);

    run_op("div_by0",  3'd4, 32'd5,        32'd0,        5'd10, 1, 32'hFFFFFFFF);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1, 32'h80000000);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 1, 32'd0);
    run_op("remu_by0", 3'd7, 32'h1234,     32'd0,        5'd13, 1, 32'h1234);

    // Flush a DIVU in cycle 10: no pulse, idle in cycle 11, previous result kept
    issue(3'd5, 32'd100, 32'd7, 5'd9);
    seen = 1'b0;
    while (cyc < 10) begin
      seen |= bus.done;
      step();
    end
    bus.flush = 1'b1;
    seen |= bus.done;
    step();
    bus.flush = 1'b0;
    check("flush_ready", {31'b0, bus.ready}, 32'd1);
    check("flush_result_kept", bus.result, 32'h1234);
    check("flush_tag_kept", {27'b0, bus.tag_out}, 32'd13);
    repeat (40) begin
      seen |= bus.done;
      step();
    end
    check("flush_no_done", {31'b0, seen}, 32'd0);

    // Stray start pulses while busy must not disturb the running DIVU
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    while (cyc < 5) step();
    check("stray_busy", {31'b0, bus.busy}, 32'd1);
    bus.start = 1'b1; bus.op = 3'd0; bus.data1 = 32'd1; bus.data2 = 32'd1; bus.tag_in = 5'd17;
    step();
    bus.start = 1'b0;
    while (cyc < 12) step();
    bus.start = 1'b1; bus.op = 3'd4; bus.data1 = 32'd9; bus.data2 = 32'd0; bus.tag_in = 5'd18;
    step();
    bus.start = 1'b0;
    wait_done("stray", 33, 32'd14, 5'd3);

    // Reset in cycle 20 of a MUL, then a fresh op straight away
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd4);
    while (cyc < 20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", {31'b0, bus.ready}, 32'd1);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_tag", {27'b0, bus.tag_out}, 32'd0);
    run_op("after_rst", 3'd0, 32'd6, 32'd7, 5'd2, 33, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It consumes the same operand pair (data1/data2) that the ALU operand-select stage produces. It accepts one operation per start/ready handshake and computes it bit-serially over DATA_WIDTH cycles. It returns a single-cycle done pulse with the result and the destination-register tag. The pipeline control stalls on busy and kills in-flight work via flush.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >= 8)
TAG_WIDTH, 5, destination-register tag width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only when ready=1
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
data1  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
data2  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
tag_in  input  TAG_WIDTH  destination-register tag
flush  input  1  synchronous kill of in-flight operation
ready  output  1  unit idle, can accept start
busy  output  1  operation in flight (= ~ready)
done  output  1  one-cycle pulse, result valid
result  output  DATA_WIDTH  operation result; held until next accept
tag_out  output  TAG_WIDTH  tag of completed operation; held with result

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; ready=1, busy=0, done=0, result=0, tag_out=0; all internal counters and accumulators cleared. Reset overrides start and flush. Reset mid-operation discards it with no done.
- States: IDLE, CALC, DONE.
- IDLE: ready=1. On start=1 (and flush=0), latch op, tag_in, operand magnitudes, and result sign.
  - Special case present -> DONE; otherwise -> CALC with count=0.
  - start with flush=1 in the same cycle is ignored.
- CALC: one iteration per cycle. count increments; after iteration DATA_WIDTH-1, go to DONE.
- DONE: done=1 for exactly this cycle; result and tag_out registered on entry. Next state is IDLE unconditionally. start is not accepted in DONE (ready=0).
- Latency from accept edge to done:
  - normal ops: done high in cycle DATA_WIDTH+1 (33 for default);
  - special cases: done high in cycle 1.
- Operand signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: data1 signed, data2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed operands are converted to magnitude at accept; the unsigned core runs; the sign is applied at DONE.
- Multiply: shift-add on a 2*DATA_WIDTH accumulator. Final product is negated (2*DATA_WIDTH two's complement) if the result sign is negative.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: restoring, one quotient bit per cycle, MSB first.
  - Quotient sign = sign(data1) XOR sign(data2), signed ops only.
  - Remainder sign = sign(data1).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (no CALC):
  - divisor=0: DIV/DIVU -> all ones; REM/REMU -> data1 unchanged.
  - Signed overflow (data1=100..0, data2=all ones) for DIV -> data1; for REM -> 0.
- flush=1 in CALC or DONE: next state IDLE, done forced 0 that cycle, result/tag_out keep previous values. flush in IDLE has no effect.
- start while busy: ignored; no latch, no state change.
- Operand inputs are sampled only at the accept edge; later changes have no effect.

Test Plan:
- Reset, then MUL data1=7, data2=0xFFFFFFFD (-3), tag 5 -> done exactly 33 cycles after accept, result=0xFFFFFFEB, tag_out=5; ready returns 1 the following cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each done at cycle 33.
- Special cases, each with done at cycle 1:
  - DIV x/0 -> 0xFFFFFFFF;
  - REMU 0x1234/0 -> 0x1234;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM same operands -> 0.
- Flush and stray start:
  - Accept DIVU, assert flush at cycle 10 -> no done pulse, ready=1 at cycle 11, result unchanged.
  - start pulses while busy -> ignored; the first op still completes with its own result/tag.
- Assert rst at cycle 20 of a MUL -> all outputs at reset values next cycle, no done. A new op accepted immediately afterwards completes correctly.
